ppm_rx_frame_ctrl: RTL and testbench

- Frame-level sequencer for the PPM receive path.
- Detects start of frame on the raw oversampled line, then enables the 2-bit symbol generator (state_in) for consecutive 8-tick symbol slots.
- Packs returned 2-bit symbols into bytes, LSB first, and hands bytes downstream with valid/ready.
- Detects end of frame (empty slot) and flags framing, overflow and length errors.

---
 rtl/ppm_rx_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_ppm_rx_frame_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_rx_frame_ctrl.sv
// Frame sequencer for the PPM receive path: SOF detect, symbol slot timing, byte packing and frame classification.
// Optional macro PPM_RX_BYTE_CNT_EN adds the frame_bytes output (bytes delivered in the last finished frame).
module ppm_rx_frame_ctrl #(
    parameter int SLOT_TICKS = 8,
    parameter int MAX_BYTES  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk16,
    input  logic             din,
    input  logic [2:0]       sym_in,
    input  logic             sym_done_in,
    output logic             state_out,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             frame_active,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       err_code
`ifdef PPM_RX_BYTE_CNT_EN
    ,
    output logic [CNT_W-1:0] frame_bytes
`endif
);

    localparam int TICK_W = $clog2(SLOT_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SLOT_TICKS - 1);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOF  = 2'd1,
        ST_RECV = 2'd2,
        ST_END  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              pulse_q, pulse_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              got_q, got_d;
    logic [1:0]        k_q, k_d;
    logic [7:0]        shift_q, shift_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_frm_q, err_frm_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_len_q, err_len_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              state_out_q, state_out_d;
    logic              frame_active_q, frame_active_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              sym_ok_s;
    logic              accept_s;
`ifdef PPM_RX_BYTE_CNT_EN
    logic [CNT_W-1:0]  frame_bytes_q, frame_bytes_d;
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d        = state_q;
        pulse_d        = ~din;
        tick_d         = tick_q;
        got_d          = got_q;
        k_d            = k_q;
        shift_d        = shift_q;
        pend_d         = pend_q;
        cnt_d          = cnt_q;
        err_frm_d      = err_frm_q;
        err_ovf_d      = err_ovf_q;
        err_len_d      = err_len_q;
        byte_out_d     = byte_out_q;
        byte_valid_d   = byte_valid_q;
        state_out_d    = state_out_q;
        frame_active_d = frame_active_q;
        frame_done_d   = 1'b0;
        frame_err_d    = 1'b0;
        err_code_d     = 2'b00;
`ifdef PPM_RX_BYTE_CNT_EN
        frame_bytes_d  = frame_bytes_q;
`endif
        sym_ok_s = sym_done_in && !sym_in[2] && (state_q == ST_RECV);
        accept_s = byte_valid_q && byte_ready;

        if (accept_s) begin
            byte_valid_d = 1'b0;
        end else begin
            byte_valid_d = byte_valid_q;
        end

        // A completed byte reads shift_q, so a symbol stored this cycle cannot corrupt it
        if (pend_q) begin
            pend_d = 1'b0;
            if (cnt_q == MAX_C) begin
                err_len_d = 1'b1;
            end else if (byte_valid_q && !byte_ready) begin
                err_ovf_d = 1'b1;
            end else begin
                byte_out_d   = shift_q;
                byte_valid_d = 1'b1;
                cnt_d        = cnt_q + CNT_W'(1);
            end
        end else begin
            pend_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (clk16 && pulse_q) begin
                    state_d        = ST_SOF;
                    frame_active_d = 1'b1;
                    k_d            = 2'd0;
                    shift_d        = 8'h00;
                    cnt_d          = {CNT_W{1'b0}};
                    got_d          = 1'b0;
                    err_frm_d      = 1'b0;
                    err_ovf_d      = 1'b0;
                    err_len_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SOF: begin
                if (clk16 && !pulse_q) begin
                    state_d     = ST_RECV;
                    state_out_d = 1'b1;
                    tick_d      = {TICK_W{1'b0}};
                    got_d       = 1'b0;
                end else begin
                    state_d = ST_SOF;
                end
            end
            ST_RECV: begin
                if (sym_ok_s) begin
                    if (got_q) begin
                        err_frm_d = 1'b1;
                    end else begin
                        shift_d[{k_q, 1'b0} +: 2] = sym_in[1:0];
                        got_d = 1'b1;
                        if (k_q == 2'd3) begin
                            pend_d = 1'b1;
                            k_d    = 2'd0;
                        end else begin
                            k_d = k_q + 2'd1;
                        end
                    end
                end else begin
                    got_d = got_q;
                end
                if (clk16) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = {TICK_W{1'b0}};
                        if (got_q || sym_ok_s) begin
                            got_d = 1'b0;
                        end else begin
                            // Empty slot: frame is over, classify it
                            state_d        = ST_END;
                            state_out_d    = 1'b0;
                            frame_active_d = 1'b0;
`ifdef PPM_RX_BYTE_CNT_EN
                            frame_bytes_d  = cnt_q;
`endif
                            if (err_len_q) begin
                                frame_err_d = 1'b1;
                                err_code_d  = 2'b11;
                            end else if (err_ovf_q) begin
                                frame_err_d = 1'b1;
                                err_code_d  = 2'b10;
                            end else if (err_frm_q || (k_q != 2'd0) || (cnt_q == {CNT_W{1'b0}})) begin
                                frame_err_d = 1'b1;
                                err_code_d  = 2'b01;
                            end else begin
                                frame_done_d = 1'b1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pulse_q        <= 1'b0;
            tick_q         <= {TICK_W{1'b0}};
            got_q          <= 1'b0;
            k_q            <= 2'd0;
            shift_q        <= 8'h00;
            pend_q         <= 1'b0;
            cnt_q          <= {CNT_W{1'b0}};
            err_frm_q      <= 1'b0;
            err_ovf_q      <= 1'b0;
            err_len_q      <= 1'b0;
            byte_out_q     <= 8'h00;
            byte_valid_q   <= 1'b0;
            state_out_q    <= 1'b0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            err_code_q     <= 2'b00;
`ifdef PPM_RX_BYTE_CNT_EN
            frame_bytes_q  <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q        <= state_d;
            pulse_q        <= pulse_d;
            tick_q         <= tick_d;
            got_q          <= got_d;
            k_q            <= k_d;
            shift_q        <= shift_d;
            pend_q         <= pend_d;
            cnt_q          <= cnt_d;
            err_frm_q      <= err_frm_d;
            err_ovf_q      <= err_ovf_d;
            err_len_q      <= err_len_d;
            byte_out_q     <= byte_out_d;
            byte_valid_q   <= byte_valid_d;
            state_out_q    <= state_out_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            frame_err_q    <= frame_err_d;
            err_code_q     <= err_code_d;
`ifdef PPM_RX_BYTE_CNT_EN
            frame_bytes_q  <= frame_bytes_d;
`endif
        end
    end

    assign state_out    = state_out_q;
    assign byte_out     = byte_out_q;
    assign byte_valid   = byte_valid_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign err_code     = err_code_q;
`ifdef PPM_RX_BYTE_CNT_EN
    assign frame_bytes  = frame_bytes_q;
`endif

endmodule

// File: tb/tb_ppm_rx_frame_ctrl.sv
// Directed self-checking bench for ppm_rx_frame_ctrl (DUT built with MAX_BYTES=2).
module tb_ppm_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk16 = 1'b0;
    logic       din = 1'b1;
    logic [2:0] sym_in = 3'b000;
    logic       sym_done_in = 1'b0;
    logic       state_out;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       frame_active;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
`ifdef PPM_RX_BYTE_CNT_EN
    logic [5:0] frame_bytes;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int       acc_cnt = 0;
    int       vcyc = 0;
    int       done_cnt = 0;
    int       err_cnt = 0;
    logic [7:0] last_byte = 8'h00;

    ppm_rx_frame_ctrl #(.SLOT_TICKS(8), .MAX_BYTES(2), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .clk16(clk16), .din(din),
        .sym_in(sym_in), .sym_done_in(sym_done_in), .state_out(state_out),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_active(frame_active), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code)
`ifdef PPM_RX_BYTE_CNT_EN
        , .frame_bytes(frame_bytes)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (byte_valid && byte_ready) begin
                acc_cnt   <= acc_cnt + 1;
                last_byte <= byte_out;
            end
            if (byte_valid) vcyc <= vcyc + 1;
            if (frame_done) done_cnt <= done_cnt + 1;
            if (frame_err)  err_cnt  <= err_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk16 tick = strobe cycle followed by a quiet cycle carrying any symbol strobe
    task automatic tick(input logic sd, input logic [2:0] s);
        clk16 = 1'b1;
        @(posedge clk); #1;
        clk16 = 1'b0; sym_done_in = sd; sym_in = s;
        @(posedge clk); #1;
        sym_done_in = 1'b0; sym_in = 3'b000;
    endtask

    task automatic start_frame();
        din = 1'b0; tick(1'b0, 3'b000); tick(1'b0, 3'b000);
        din = 1'b1; tick(1'b0, 3'b000); tick(1'b0, 3'b000);
    endtask

    // n = number of valid symbol strobes in the slot, inv adds an invalid strobe
    task automatic slot(input logic [1:0] s, input int n, input logic inv);
        for (int t = 0; t < 8; t++) begin
            if ((n >= 1 && t == 2) || (n >= 2 && t == 5))
                tick(1'b1, {1'b0, s});
            else if (inv && t == 4)
                tick(1'b1, 3'b111);
            else
                tick(1'b0, 3'b000);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        slot(b[1:0], 1, 1'b0); slot(b[3:2], 1, 1'b0);
        slot(b[5:4], 1, 1'b0); slot(b[7:6], 1, 1'b0);
    endtask

    task automatic end_frame(input string tag, input logic ed, input logic ee,
                             input logic [1:0] ec, input int eb);
        for (int t = 0; t < 7; t++) tick(1'b0, 3'b000);
        clk16 = 1'b1;
        @(posedge clk); #1;
        clk16 = 1'b0;
        @(negedge clk);
        check({tag, ".frame_done"}, frame_done, ed);
        check({tag, ".frame_err"}, frame_err, ee);
        check({tag, ".err_code"}, err_code, ec);
        check({tag, ".frame_active_end"}, frame_active, 1'b0);
`ifdef PPM_RX_BYTE_CNT_EN
        check({tag, ".frame_bytes"}, frame_bytes, eb);
`else
        if (eb < 0) $display("note: negative byte count");
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, ".pulse_cleared"}, {frame_done, frame_err}, 2'b00);
        check({tag, ".state_out_after"}, state_out, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int a0, v0, d0, e0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.state_out", state_out, 1'b0);
        check("rst.frame_active", frame_active, 1'b0);
        check("rst.byte_valid", byte_valid, 1'b0);
        check("rst.byte_out", byte_out, 8'h00);
        check("rst.pulses", {frame_done, frame_err, err_code}, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Clean one-byte frame 0x36 with an ignored invalid strobe
        byte_ready = 1'b1;
        a0 = acc_cnt; v0 = vcyc; d0 = done_cnt; e0 = err_cnt;
        start_frame();
        @(negedge clk);
        check("clean.state_out", state_out, 1'b1);
        check("clean.frame_active", frame_active, 1'b1);
        slot(2'd2, 1, 1'b1); slot(2'd1, 1, 1'b0); slot(2'd3, 1, 1'b0); slot(2'd0, 1, 1'b0);
        end_frame("clean", 1'b1, 1'b0, 2'b00, 1);
        check("clean.accepts", acc_cnt - a0, 1);
        check("clean.byte", last_byte, 8'h36);
        check("clean.valid_cycles", vcyc - v0, 1);
        check("clean.done_pulses", done_cnt - d0, 1);
        check("clean.err_pulses", err_cnt - e0, 0);

        // Back-pressure: 0xA5 held, 0x3C dropped as overflow
        byte_ready = 1'b0;
        a0 = acc_cnt;
        start_frame();
        send_byte(8'hA5);
        @(negedge clk);
        check("bp.valid1", byte_valid, 1'b1);
        check("bp.byte1", byte_out, 8'hA5);
        send_byte(8'h3C);
        @(negedge clk);
        check("bp.held", byte_out, 8'hA5);
        check("bp.valid_held", byte_valid, 1'b1);
        end_frame("bp", 1'b0, 1'b1, 2'b10, 1);
        @(negedge clk);
        check("bp.valid_survives", byte_valid, 1'b1);
        byte_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp.valid_cleared", byte_valid, 1'b0);
        check("bp.accepted", last_byte, 8'hA5);
        check("bp.accepts", acc_cnt - a0, 1);

        // Partial byte: three symbols then an empty slot
        a0 = acc_cnt; v0 = vcyc;
        start_frame();
        slot(2'd0, 1, 1'b0); slot(2'd1, 1, 1'b0); slot(2'd2, 1, 1'b0);
        end_frame("partial", 1'b0, 1'b1, 2'b01, 0);
        check("partial.no_valid", vcyc - v0, 0);

        // Double symbol in the first slot: byte 0x1B still delivered, framing error
        a0 = acc_cnt;
        start_frame();
        slot(2'd3, 2, 1'b0); slot(2'd2, 1, 1'b0); slot(2'd1, 1, 1'b0); slot(2'd0, 1, 1'b0);
        end_frame("double", 1'b0, 1'b1, 2'b01, 1);
        check("double.accepts", acc_cnt - a0, 1);
        check("double.byte", last_byte, 8'h1B);

        // Length: third byte exceeds MAX_BYTES=2
        a0 = acc_cnt;
        start_frame();
        send_byte(8'h36); send_byte(8'hA5); send_byte(8'h3C);
        end_frame("len", 1'b0, 1'b1, 2'b11, 2);
        check("len.accepts", acc_cnt - a0, 2);
        check("len.last_byte", last_byte, 8'hA5);

        // Reset mid-frame with a pending byte
        byte_ready = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        start_frame();
        send_byte(8'h5A);
        slot(2'd1, 1, 1'b0); slot(2'd2, 1, 1'b0);
        @(negedge clk);
        check("rstmid.pending", byte_valid, 1'b1);
        check("rstmid.active_before", state_out, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.state_out", state_out, 1'b0);
        check("rstmid.frame_active", frame_active, 1'b0);
        check("rstmid.byte_valid", byte_valid, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("rstmid.no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        byte_ready = 1'b1;
        a0 = acc_cnt;
        start_frame();
        send_byte(8'h36);
        end_frame("after_rst", 1'b1, 1'b0, 2'b00, 1);
        check("after_rst.accepts", acc_cnt - a0, 1);
        check("after_rst.byte", last_byte, 8'h36);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
